pixel_stream_tx: RTL

Raster-order RGB pixel transmitter for the front end of the convolution pipeline. It reads an INPUT_SIZE×INPUT_SIZE frame from a synchronous-read frame buffer and drives the convolution input stream: `stage1_en` plus `pixel_r`, `pixel_g` and `pixel_b`, one pixel per cycle. It sits between the frame buffer and the convolution core and supplies exactly the row-major stream the core's input counters expect. Consumer-side pacing uses a `hold` input that throttles new reads.

---
 rtl/pixel_stream_pkg.sv | 24 ++
 rtl/pixel_stream_tx.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/pixel_stream_pkg.sv
// pixel_stream_pkg: shared state type, RGB field layout and pixel width for
// the raster-order pixel stream transmitter.
package pixel_stream_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } tx_state_t;

  localparam int PIX_W = 8;
  localparam int R_MSB = 23;
  localparam int G_MSB = 15;
  localparam int B_MSB = 7;

  // Zero-extended R+G+B of one 24-bit frame-buffer word.
  function automatic logic [31:0] rgb_sum(input logic [23:0] word);
    rgb_sum = {24'd0, word[R_MSB -: PIX_W]}
            + {24'd0, word[G_MSB -: PIX_W]}
            + {24'd0, word[B_MSB -: PIX_W]};
  endfunction

endpackage

// File: rtl/pixel_stream_tx.sv
// pixel_stream_tx: reads an INPUT_SIZE x INPUT_SIZE frame from a
// synchronous-read frame buffer in row-major order and emits one RGB pixel
// per cycle on stage1_en / pixel_r / pixel_g / pixel_b. The hold input stops
// new reads; data already requested still drains to the output.
// Optional build macro: PIX_TX_CHECKSUM_EN adds the frame_sum checksum port.
module pixel_stream_tx
  import pixel_stream_pkg::*;
#(
  parameter int INPUT_SIZE = 64,
  parameter int ADDR_W     = $clog2(INPUT_SIZE * INPUT_SIZE)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              hold,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [23:0]       mem_rdata,
  output logic              stage1_en,
  output logic [PIX_W-1:0]  pixel_r,
  output logic [PIX_W-1:0]  pixel_g,
  output logic [PIX_W-1:0]  pixel_b,
  output logic              busy,
  output logic              frame_done
`ifdef PIX_TX_CHECKSUM_EN
  ,
  output logic [31:0]       frame_sum
`endif
);

  localparam logic [ADDR_W-1:0] ADDR_ZERO = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(INPUT_SIZE * INPUT_SIZE - 1);

  tx_state_t         state_r;
  tx_state_t         state_nxt_s;
  logic [ADDR_W-1:0] addr_cnt_r;
  logic [ADDR_W-1:0] addr_cnt_nxt_s;
  logic [ADDR_W-1:0] issue_addr_s;
  logic              issue_s;
  logic              start_acc_s;
  logic              rd_valid_r;

  assign start_acc_s = (state_r == IDLE) && start;

  // Next-state, read-issue and address-counter decisions.
  always_comb begin
    state_nxt_s    = state_r;
    issue_s        = 1'b0;
    issue_addr_s   = addr_cnt_r;
    addr_cnt_nxt_s = addr_cnt_r;
    case (state_r)
      IDLE: begin
        if (start_acc_s) begin
          // The start edge itself issues address 0 unless the consumer stalls.
          state_nxt_s  = STREAM;
          issue_addr_s = ADDR_ZERO;
          if (hold) begin
            addr_cnt_nxt_s = ADDR_ZERO;
          end else begin
            issue_s        = 1'b1;
            addr_cnt_nxt_s = ADDR_ONE;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      STREAM: begin
        if (hold) begin
          state_nxt_s = STREAM;
        end else begin
          issue_s        = 1'b1;
          addr_cnt_nxt_s = addr_cnt_r + ADDR_ONE;
          if (addr_cnt_r == LAST_ADDR) begin
            state_nxt_s = DRAIN;
          end else begin
            state_nxt_s = STREAM;
          end
        end
      end
      DRAIN: begin
        // Both the outstanding request and the returning word must be gone.
        if (!mem_rd_en && !rd_valid_r) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      DONE: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // FSM state, address counter and registered read-port / status outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r    <= IDLE;
      addr_cnt_r <= ADDR_ZERO;
      mem_rd_en  <= 1'b0;
      mem_addr   <= ADDR_ZERO;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      addr_cnt_r <= addr_cnt_nxt_s;
      mem_rd_en  <= issue_s;
      if (issue_s) begin
        mem_addr <= issue_addr_s;
      end else begin
        mem_addr <= mem_addr;
      end
      busy       <= (state_nxt_s == STREAM) || (state_nxt_s == DRAIN);
      frame_done <= (state_nxt_s == DONE);
    end
  end

  // Read-data pipeline: the word requested last cycle is captured as a pixel.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_valid_r <= 1'b0;
      stage1_en  <= 1'b0;
      pixel_r    <= {PIX_W{1'b0}};
      pixel_g    <= {PIX_W{1'b0}};
      pixel_b    <= {PIX_W{1'b0}};
    end else begin
      rd_valid_r <= mem_rd_en;
      stage1_en  <= rd_valid_r;
      if (rd_valid_r) begin
        pixel_r <= mem_rdata[R_MSB -: PIX_W];
        pixel_g <= mem_rdata[G_MSB -: PIX_W];
        pixel_b <= mem_rdata[B_MSB -: PIX_W];
      end else begin
        pixel_r <= pixel_r;
        pixel_g <= pixel_g;
        pixel_b <= pixel_b;
      end
    end
  end

`ifdef PIX_TX_CHECKSUM_EN
  // Per-frame R+G+B checksum, cleared at start accept and held after the frame.
  always_ff @(posedge clk) begin
    if (!reset) begin
      frame_sum <= 32'd0;
    end else if (start_acc_s) begin
      frame_sum <= 32'd0;
    end else if (rd_valid_r) begin
      frame_sum <= frame_sum + rgb_sum(mem_rdata);
    end else begin
      frame_sum <= frame_sum;
    end
  end
`endif

endmodule
